// File: rtl/arb_pkg.sv
// Shared constants for the eight-requester arbiter and its winner picker.
package arb_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned IDW  = 3;
  localparam int unsigned CNTW = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/rr_pick8.sv
// Combinational winner search: highest index (fixed) or first set bit at/after ptr (round-robin).
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic           any,
  output logic [IDW-1:0] win_id
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;

  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    hi_id = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) hi_id = IDW'(i);
    end
    // Rotated so that bit 0 is the requester at ptr; lowest set bit is the next in line.
    lo_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) lo_id = IDW'(i);
    end
    any    = |req;
    win_id = mode ? IDW'(lo_id + ptr) : hi_id;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester arbiter: grant held until done, request drop, or MAX_HOLD timeout.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout,
  output logic           idle
);

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [0:0]      state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [N-1:0]    gnt_nxt;
  logic [IDW-1:0]  gnt_id_nxt;
  logic            gnt_valid_nxt;
  logic            timeout_nxt;
  logic            idle_nxt;
  logic            pick_any;
  logic [IDW-1:0]  pick_id;
  logic            rel_done;
  logic            rel_to;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .mode   (mode),
    .any    (pick_any),
    .win_id (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      idle      <= 1'b1;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
      idle      <= idle_nxt;
    end
  end

  // Next-state and next-output logic; gnt_id keeps the last owner after release.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    idle_nxt      = idle;
    rel_done      = done | ~req[gnt_id];
    rel_to        = HOLD_EN && (cnt == HOLD_LAST);

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt     = GRANT;
          gnt_nxt       = N'(1) << pick_id;
          gnt_id_nxt    = pick_id;
          gnt_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          idle_nxt      = 1'b0;
        end else begin
          idle_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (rel_done || rel_to) begin
          state_nxt     = IDLE;
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          idle_nxt      = 1'b1;
          ptr_nxt       = IDW'(gnt_id + IDW'(1));
          timeout_nxt   = rel_to & ~rel_done;
        end else begin
          cnt_nxt = CNTW'(cnt + CNTW'(1));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a behavioural model queues expected outputs, a monitor checks them.
module tb_rr_arbiter8;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       idle;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .idle      (idle)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
    logic       idle;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_g;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model: owner index (-1 = free), cycles held so far, round-robin start point.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_id;
  bit m_to;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_id    = 0;
    m_to    = 1'b0;
  endtask

  function automatic int pick(input logic [7:0] r, input logic md);
    int idx;
    if (!md) begin
      for (int i = 7; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (r[idx]) return idx;
      end
    end
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    e.id    = 3'(m_id);
    e.valid = (m_owner >= 0);
    e.to    = m_to;
    e.idle  = (m_owner < 0);
    return e;
  endfunction

  task automatic step_now(input logic [7:0] r, input logic d, input logic md);
    bit rel_d;
    bit rel_t;
    req  = r;
    done = d;
    mode = md;
    if (m_owner < 0) begin
      m_to = 1'b0;
      if (r != 8'h00) begin
        m_owner = pick(r, md);
        m_id    = m_owner;
        m_held  = 1;
      end
    end else begin
      rel_d = d || !r[m_owner];
      rel_t = (HOLD != 0) && (m_held == HOLD);
      if (rel_d || rel_t) begin
        m_to    = rel_t && !rel_d;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
    sb_q.push_back(model_out());
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic md);
    @(negedge clk);
    step_now(r, d, md);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'h0);
    chk({nm, "_id"}, 32'(gnt_id), 32'h0);
    chk({nm, "_valid"}, 32'(gnt_valid), 32'h0);
    chk({nm, "_timeout"}, 32'(timeout), 32'h0);
    chk({nm, "_idle"}, 32'(idle), 32'h1);
  endtask

  // Monitor: one expected record per clock while the scoreboard has entries.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_g = {gnt, gnt_id, gnt_valid, timeout, idle};
      checks++;
      if (mon_g !== mon_e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got gnt=%h id=%0d v=%b to=%b idle=%b want gnt=%h id=%0d v=%b to=%b idle=%b",
                 cyc, mon_g.gnt, mon_g.id, mon_g.valid, mon_g.to, mon_g.idle,
                 mon_e.gnt, mon_e.id, mon_e.valid, mon_e.to, mon_e.idle);
      end
      checks++;
      if (((gnt & (gnt - 8'h01)) != 8'h00) || (gnt_valid !== (gnt != 8'h00)) || (idle && gnt_valid)) begin
        failures++;
        $display("FAIL invariant cyc=%0d got gnt=%h v=%b idle=%b", cyc, gnt, gnt_valid, idle);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    mode  = 1'b0;
    done  = 1'b0;
    model_reset();

    // Outputs hold reset values while rst_n is low, even with requests pending.
    repeat (3) begin
      @(posedge clk);
      #2;
      chk_reset_vals("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_now(8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("first_grant", 32'(gnt), 32'h80);
    step(8'hFF, 1'b1, 1'b0);

    // Round-robin with done pulsed on every grant.
    repeat (20) step(8'hFF, (m_owner >= 0), 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Wrap-around: leave ptr at 6, then only requesters 0 and 1.
    step(8'h20, 1'b0, 1'b1);
    step(8'h20, 1'b1, 1'b1);
    step(8'h03, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    chk("wrap_id", 32'(gnt_id), 32'h0);
    step(8'h03, 1'b1, 1'b1);
    step(8'h03, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    chk("ptr_after_wrap", 32'(gnt_id), 32'h1);
    step(8'h03, 1'b1, 1'b1);

    // Hold timeout with a single steady requester.
    step(8'h00, 1'b0, 1'b0);
    repeat (14) step(8'h08, 1'b0, 1'b0);

    // Owner drops its request without done.
    step(8'h00, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Random traffic; the owner usually keeps its request up.
    repeat (400) begin
      logic [7:0] r;
      r = 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 9) < 7) r[m_owner] = 1'b1;
      step(r, ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    // Reset in the middle of a grant.
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    chk("pre_reset_valid", 32'(gnt_valid), 32'h1);
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step_now(8'hFF, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    chk("post_reset_id", 32'(gnt_id), 32'h0);
    step(8'hFF, 1'b1, 1'b1);
    step(8'hFF, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
